// File: rtl/wb_regbank_param_if.sv
// Pipelined Wishbone slave bundle for the parametrised register bank.
// Signal names keep the slave-side _i/_o direction suffixes.
interface wb_regbank_param_if #(
  parameter int ADR_W = 4
);
  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [ADR_W+1:2]  wb_adr_i;
  logic [3:0]        wb_sel_i;
  logic [31:0]       wb_dat_i;
  logic              wb_ack_o;
  logic              wb_err_o;
  logic              wb_rty_o;
  logic              wb_stall_o;
  logic [31:0]       wb_dat_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o, wb_dat_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o, wb_dat_o
  );
endinterface

// File: rtl/wb_regbank_param.sv
// Wishbone register bank: NUM_REGS byte-lane control registers, a sticky W1C
// event STATUS register with MASK-gated interrupt, and error on unmapped words.
module wb_regbank_param #(
  parameter int          NUM_REGS  = 4,
  parameter int          ADR_W     = 4,
  parameter int          FIELD_W   = 8,
  parameter logic [31:0] RESET_VAL = 32'h0,
  parameter int          EVT_W     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  wb_regbank_param_if.slave            wb,
  output logic [NUM_REGS*FIELD_W-1:0]  ctrl_o,
  output logic [NUM_REGS-1:0]          ctrl_wr_o,
  input  logic [EVT_W-1:0]             evt_i,
  output logic                         irq_o
);

  localparam logic [ADR_W-1:0]   ADR_STATUS = ADR_W'(NUM_REGS);
  localparam logic [ADR_W-1:0]   ADR_MASK   = ADR_W'(NUM_REGS + 1);
  localparam logic [FIELD_W-1:0] CTRL_RST   = RESET_VAL[FIELD_W-1:0];

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{sel[b]}};
    return m;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  logic [FIELD_W-1:0]  ctrl_q [NUM_REGS];
  logic [FIELD_W-1:0]  ctrl_d [NUM_REGS];
  logic [EVT_W-1:0]    status_q, status_d;
  logic [EVT_W-1:0]    mask_q, mask_d;
  logic [NUM_REGS-1:0] ctrl_wr_q, ctrl_wr_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [31:0]         dat_q, dat_d;
  logic                rd_busy_q, rd_busy_d;
  logic                wr_busy_q, wr_busy_d;

  logic                wr_vld_p0, wr_vld_p1;
  logic [ADR_W-1:0]    wr_adr_p0;
  logic [31:0]         wr_dat_p0;
  logic [3:0]          wr_sel_p0;

  logic                rd_acc, wr_acc;
  logic                rd_hit;
  logic [31:0]         rd_data;
  logic [NUM_REGS-1:0] wr_ctrl_hit;
  logic                wr_status_hit, wr_mask_hit, wr_map;
  logic [31:0]         bm;
  logic [EVT_W-1:0]    clr;

  // A direction stays blocked from accept through its response cycle.
  assign rd_acc = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_we_i & ~rd_busy_q;
  assign wr_acc = wb.wb_cyc_i & wb.wb_stb_i &  wb.wb_we_i & ~wr_busy_q;

  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wb.wb_adr_i == ADR_W'(i)) begin
        rd_hit  = 1'b1;
        rd_data = 32'(ctrl_q[i]);
      end
    end
    if (wb.wb_adr_i == ADR_STATUS) begin
      rd_hit  = 1'b1;
      rd_data = 32'(status_q);
    end
    if (wb.wb_adr_i == ADR_MASK) begin
      rd_hit  = 1'b1;
      rd_data = 32'(mask_q);
    end
  end

  // Stage p0: registered write address/data/sel, applied at the end of T+1
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      wr_adr_p0 <= wb.wb_adr_i;
      wr_dat_p0 <= wb.wb_dat_i;
      wr_sel_p0 <= wb.wb_sel_i;
    end
  end

  always_comb begin
    bm          = lane_mask(wr_sel_p0);
    wr_ctrl_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_vld_p0 && (wr_adr_p0 == ADR_W'(i))) wr_ctrl_hit[i] = 1'b1;
    end
    wr_status_hit = wr_vld_p0 && (wr_adr_p0 == ADR_STATUS);
    wr_mask_hit   = wr_vld_p0 && (wr_adr_p0 == ADR_MASK);
    wr_map        = (|wr_ctrl_hit) | wr_status_hit | wr_mask_hit;

    for (int i = 0; i < NUM_REGS; i++) begin
      ctrl_d[i] = wr_ctrl_hit[i] ? FIELD_W'(merge_lanes(32'(ctrl_q[i]), wr_dat_p0, bm))
                                 : ctrl_q[i];
    end
    clr      = wr_status_hit ? EVT_W'(wr_dat_p0 & bm) : '0;
    // Set is applied after clear so a same-cycle event wins.
    status_d = (status_q & ~clr) | evt_i;
    mask_d   = wr_mask_hit ? EVT_W'(merge_lanes(32'(mask_q), wr_dat_p0, bm)) : mask_q;

    ctrl_wr_d = wr_ctrl_hit;
    ack_d     = (rd_acc & rd_hit)  | (wr_vld_p0 & wr_map);
    err_d     = (rd_acc & ~rd_hit) | (wr_vld_p0 & ~wr_map);
    dat_d     = rd_acc ? rd_data : '0;
    rd_busy_d = rd_acc;
    wr_busy_d = wr_acc | (wr_busy_q & ~wr_vld_p1);
  end

  // Stage p1: architectural state, responses and strobes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) ctrl_q[i] <= CTRL_RST;
      status_q  <= '0;
      mask_q    <= '0;
      ctrl_wr_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      rd_busy_q <= 1'b0;
      wr_busy_q <= 1'b0;
      wr_vld_p0 <= 1'b0;
      wr_vld_p1 <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) ctrl_q[i] <= ctrl_d[i];
      status_q  <= status_d;
      mask_q    <= mask_d;
      ctrl_wr_q <= ctrl_wr_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
      rd_busy_q <= rd_busy_d;
      wr_busy_q <= wr_busy_d;
      wr_vld_p0 <= wr_acc;
      wr_vld_p1 <= wr_vld_p0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl
    assign ctrl_o[g*FIELD_W +: FIELD_W] = ctrl_q[g];
  end

  assign ctrl_wr_o     = ctrl_wr_q;
  assign irq_o         = |(status_q & mask_q);
  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_err_o   = err_q;
  assign wb.wb_rty_o   = 1'b0;
  assign wb.wb_dat_o   = dat_q;
  assign wb.wb_stall_o = wb.wb_cyc_i & wb.wb_stb_i & ~(ack_q | err_q);

endmodule
